// File: rtl/serial_operand_serializer.sv
// serial_operand_serializer
// Takes a parallel operand pair over a valid/ready handshake and streams it
// LSB-first as one bit of A and one bit of B per beat, qualified by vld and
// last. A new word can be accepted in the same cycle as the previous word's
// last beat, so back-to-back words stream with no bubble. en stalls the stream.

module serial_operand_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             en,
    output logic             vld,
    output logic             a,
    output logic             b,
    output logic             last
);

    // With WIDTH=1 the counter keeps one bit. It never leaves 0, because
    // every beat is the last beat.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CNT_W-1:0] cnt;

    logic shifting;
    logic at_last;
    logic accept;

    // Outputs come only from registered state and en. The parallel inputs
    // never reach the serial outputs combinationally.
    assign shifting = (state == SHIFT);
    assign at_last  = (cnt == CNT_LAST);
    assign vld      = shifting & en;
    assign last     = vld & at_last;
    assign in_rdy   = ~shifting | last;
    assign a        = shifting & sh_a[0];
    assign b        = shifting & sh_b[0];
    assign accept   = in_vld & in_rdy;

    // Sequencer. Priority is: load a new word, retire the word on its last
    // beat, then advance one beat. A stall falls through every branch and
    // holds the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            sh_a  <= '0;
            sh_b  <= '0;
        end else if (accept) begin
            state <= SHIFT;
            cnt   <= '0;
            sh_a  <= in_a;
            sh_b  <= in_b;
        end else if (last) begin
            state <= IDLE;
            cnt   <= '0;
            sh_a  <= '0;
            sh_b  <= '0;
        end else if (vld) begin
            cnt   <= cnt + CNT_W'(1);
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
        end
    end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Testbench for serial_operand_serializer.
// It drives one WIDTH=8 instance and one WIDTH=1 instance. Accepted words are
// expanded into per-beat expectations in scoreboard queues, and those queues
// are checked every cycle on the falling edge.

module tb_serial_operand_serializer;

    typedef struct packed {
        logic a;
        logic b;
        logic last;
    } beat_t;

    logic       clk;
    logic       rst;

    // Signals for the WIDTH=8 instance.
    logic       in_vld;
    logic       in_rdy;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       en;
    logic       vld;
    logic       a;
    logic       b;
    logic       last;

    // Signals for the WIDTH=1 instance.
    logic       in_vld1;
    logic       in_rdy1;
    logic [0:0] in_a1;
    logic [0:0] in_b1;
    logic       en1;
    logic       vld1;
    logic       a1;
    logic       b1;
    logic       last1;

    int errors = 0;
    int checks = 0;

    beat_t      q8[$];
    beat_t      q1[$];
    logic [7:0] sum_q[$];
    logic [7:0] sum_acc;
    int         sum_idx;
    logic       carry;

    serial_operand_serializer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
        .in_a(in_a), .in_b(in_b), .en(en),
        .vld(vld), .a(a), .b(b), .last(last)
    );

    serial_operand_serializer #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_vld(in_vld1), .in_rdy(in_rdy1),
        .in_a(in_a1), .in_b(in_b1), .en(en1),
        .vld(vld1), .a(a1), .b(b1), .last(last1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Wait, with a cycle budget, until every scoreboarded beat has been seen.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q8.size() != 0 || q1.size() != 0) && n < 40) begin
            cyc();
            n++;
        end
        check(tag, q8.size() + q1.size(), 0);
    endtask

    // Falling-edge monitor for the WIDTH=8 instance. It compares beats against
    // the scoreboard, rebuilds the adder sum from the stream, and then
    // enqueues any word accepted at the coming rising edge.
    always @(negedge clk) begin
        beat_t      e;
        logic [7:0] s;
        if (!rst) begin
            q8.delete();
            sum_q.delete();
            sum_idx = 0;
            carry   = 1'b0;
            sum_acc = '0;
            check("w8_reset_out", {in_rdy, vld, a, b, last}, 5'b10000);
        end else begin
            if (q8.size() == 0) begin
                check("w8_idle_out", {in_rdy, vld, a, b, last}, 5'b10000);
            end else if (vld) begin
                e = q8.pop_front();
                check("w8_beat", {a, b, last, in_rdy}, {e.a, e.b, e.last, e.last});
                sum_acc[sum_idx] = a ^ b ^ carry;
                carry = (a & b) | (carry & (a ^ b));
                sum_idx++;
                if (e.last) begin
                    check("w8_sum", sum_acc, sum_q.pop_front());
                    sum_idx = 0;
                    carry   = 1'b0;
                end
            end else begin
                check("w8_stall_hold", {a, b, last, in_rdy}, {q8[0].a, q8[0].b, 2'b00});
            end
            if (in_vld && in_rdy) begin
                for (int i = 0; i < 8; i++) begin
                    q8.push_back('{a: in_a[i], b: in_b[i], last: (i == 7)});
                end
                s = in_a + in_b;
                sum_q.push_back(s);
            end
        end
    end

    // Falling-edge monitor for the WIDTH=1 instance.
    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            q1.delete();
        end else begin
            if (q1.size() == 0) begin
                check("w1_idle_out", {in_rdy1, vld1, a1, b1, last1}, 5'b10000);
            end else if (vld1) begin
                e = q1.pop_front();
                check("w1_beat", {a1, b1, last1, in_rdy1}, {e.a, e.b, 2'b11});
            end else begin
                check("w1_stall_hold", {a1, b1, last1, in_rdy1}, {q1[0].a, q1[0].b, 2'b00});
            end
            if (in_vld1 && in_rdy1) begin
                q1.push_back('{a: in_a1[0], b: in_b1[0], last: 1'b1});
            end
        end
    end

    // Directed stimulus
    initial begin
        logic [7:0] wa;
        logic [7:0] wb;

        rst = 1'b0; in_vld = 1'b0; in_a = '0; in_b = '0; en = 1'b1;
        in_vld1 = 1'b0; in_a1 = '0; in_b1 = '0; en1 = 1'b1;

        $display("[TB] reset");
        repeat (3) cyc();
        check("reset_held", {in_rdy, vld, a, b, last}, 5'b10000);
        rst = 1'b1;
        repeat (3) cyc();
        check("idle_after_reset", {in_rdy, vld, last}, 3'b100);

        $display("[TB] single word A5/3C");
        wa = 8'hA5; wb = 8'h3C;
        in_a = wa; in_b = wb; in_vld = 1'b1;
        cyc();
        in_vld = 1'b0; in_a = 8'h00; in_b = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            check("single_bits", {vld, a, b, last, in_rdy}, {1'b1, wa[i], wb[i], i == 7, i == 7});
            cyc();
        end
        check("single_done", {vld, in_rdy}, 2'b01);
        drain("single_drain");

        $display("[TB] back-to-back FF/01 then 0F/0F");
        in_a = 8'hFF; in_b = 8'h01; in_vld = 1'b1;
        cyc();
        in_a = 8'h0F; in_b = 8'h0F;
        for (int k = 0; k < 16; k++) begin
            check("b2b_vld_last", {vld, last}, {1'b1, (k == 7) || (k == 15)});
            if (k == 7) check("b2b_second_accept", {in_rdy, in_vld}, 2'b11);
            cyc();
            if (k == 7) in_vld = 1'b0;
        end
        check("b2b_no_bubble_after", vld, 1'b0);
        drain("b2b_drain");

        $display("[TB] stall during beats 3-5");
        in_a = 8'hA5; in_b = 8'h3C; in_vld = 1'b1;
        cyc();
        in_vld = 1'b0;
        cyc();
        cyc();
        en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("stall_out", {vld, last, a, b, in_rdy}, 5'b00110);
            cyc();
        end
        en = 1'b1;
        #1;
        check("stall_resume_bit2", {vld, a, b}, 3'b111);
        drain("stall_drain");

        $display("[TB] WIDTH=1 back-to-back");
        in_a1 = 1'b1; in_b1 = 1'b1; in_vld1 = 1'b1;
        cyc();
        in_a1 = 1'b0; in_b1 = 1'b1;
        check("w1_beat0", {vld1, last1, a1, b1}, 4'b1111);
        cyc();
        in_a1 = 1'b1; in_b1 = 1'b0;
        check("w1_beat1", {vld1, last1, a1, b1}, 4'b1101);
        cyc();
        in_vld1 = 1'b0;
        check("w1_beat2", {vld1, last1, a1, b1}, 4'b1110);
        cyc();
        check("w1_done", {vld1, in_rdy1}, 2'b01);
        drain("w1_drain");

        $display("[TB] reset mid-word");
        in_a = 8'hA5; in_b = 8'h3C; in_vld = 1'b1;
        cyc();
        in_vld = 1'b0;
        repeat (3) cyc();
        check("pre_reset_beat4", {vld, a, b}, 3'b101);
        #1;
        rst = 1'b0;
        #1;
        check("async_reset_out", {in_rdy, vld, a, b, last}, 5'b10000);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        check("post_reset_idle", {in_rdy, vld}, 2'b10);
        wa = 8'h12; wb = 8'h34;
        in_a = wa; in_b = wb; in_vld = 1'b1;
        cyc();
        in_vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("after_reset_bits", {vld, a, b, last}, {1'b1, wa[i], wb[i], i == 7});
            cyc();
        end
        drain("after_reset_drain");
        check("sum_queue_empty", sum_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
